// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one instruction at a time to a downstream registered ALU.
// It reads operands from an 8-entry register file, waits ALU_LAT edges for the
// result, then writes it back during a single WB cycle.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   instr_valid/instr_ready      instruction handshake; instr = {op, rd, rs2, rs3}
//   ALUop, r2, r3                registered op/operands driven to the ALU
//   r0                           ALU result
//   ld_valid/ld_addr/ld_data     direct register-file load port (any state)
//   wb_valid/wb_addr/wb_data     writeback strobe, destination and result
//   err                          one-cycle pulse after an illegal op (7) is accepted
//   dbg_raddr/dbg_rdata          combinational register-file read
module alu_issue_ctrl #(
  parameter int unsigned n       = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [11:0]  instr,
  output logic [2:0]   ALUop,
  output logic [n-1:0] r2,
  output logic [n-1:0] r3,
  input  logic [n-1:0] r0,
  input  logic         ld_valid,
  input  logic [2:0]   ld_addr,
  input  logic [n-1:0] ld_data,
  output logic         wb_valid,
  output logic [2:0]   wb_addr,
  output logic [n-1:0] wb_data,
  output logic         err,
  input  logic [2:0]   dbg_raddr,
  output logic [n-1:0] dbg_rdata
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned NREG   = 8;
  localparam logic [2:0]  OP_ILL = 3'd7;

  typedef enum logic [1:0] {IDLE, WAIT, WB} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         rd_q;
  logic [2:0]         aluop_q;
  logic [n-1:0]       r2_q;
  logic [n-1:0]       r3_q;
  logic               ready_q;
  logic               wb_valid_q;
  logic [2:0]         wb_addr_q;
  logic [n-1:0]       wb_data_q;
  logic               err_q;
  logic [n-1:0]       rf_q [NREG];

  logic               accept_c;
  logic [2:0]         op_c;

  // Instruction field decode and handshake
  always_comb begin
    op_c     = instr[11:9];
    accept_c = instr_valid && ready_q;
  end

  // Issue FSM, register file and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= '0;
      aluop_q    <= '0;
      r2_q       <= '0;
      r3_q       <= '0;
      ready_q    <= 1'b1;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      err_q <= 1'b0;

      // Load port; a writeback to the same entry below is assigned later and wins
      if (ld_valid && (ld_addr != 3'd0)) rf_q[ld_addr] <= ld_data;

      case (state_q)
        IDLE: begin
          if (accept_c) begin
            if (op_c == OP_ILL) begin
              err_q <= 1'b1;
            end else begin
              aluop_q <= op_c;
              r2_q    <= rf_q[instr[5:3]];
              r3_q    <= rf_q[instr[2:0]];
              rd_q    <= instr[8:6];
              cnt_q   <= CNT_W'(ALU_LAT);
              ready_q <= 1'b0;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q    <= WB;
            wb_valid_q <= 1'b1;
            wb_addr_q  <= rd_q;
          end
        end
        WB: begin
          wb_valid_q <= 1'b0;
          wb_data_q  <= r0;
          if (rd_q != 3'd0) rf_q[rd_q] <= r0;
          ready_q    <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The ALU result only becomes valid at the edge that enters WB, so wb_data
  // passes r0 through during WB and holds the captured value otherwise.
  assign wb_data     = (state_q == WB) ? r0 : wb_data_q;
  assign instr_ready = ready_q;
  assign ALUop       = aluop_q;
  assign r2          = r2_q;
  assign r3          = r3_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign err         = err_q;
  assign dbg_rdata   = (dbg_raddr == 3'd0) ? '0 : rf_q[dbg_raddr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: closes the loop with a registered 32-bit ALU model
// (latency 1), checks issue/writeback timing directly and writeback contents
// through a queue of expected {addr, data} entries.
module tb_alu_issue_ctrl;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         instr_valid;
  logic         instr_ready;
  logic [11:0]  instr;
  logic [2:0]   ALUop;
  logic [W-1:0] r2, r3, r0;
  logic         ld_valid;
  logic [2:0]   ld_addr;
  logic [W-1:0] ld_data;
  logic         wb_valid;
  logic [2:0]   wb_addr;
  logic [W-1:0] wb_data;
  logic         err;
  logic [2:0]   dbg_raddr;
  logic [W-1:0] dbg_rdata;

  typedef struct {
    logic [2:0]   addr;
    logic [W-1:0] data;
  } wb_t;

  typedef struct {
    logic [11:0]  ins;
    logic [2:0]   e_op;
    logic [W-1:0] e_r2;
    logic [W-1:0] e_r3;
    logic [2:0]   e_addr;
    logic [W-1:0] e_data;
    logic [W-1:0] e_rf;
  } vec_t;

  wb_t  sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  alu_issue_ctrl #(.n(W), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ALUop(ALUop), .r2(r2), .r3(r3), .r0(r0),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .err(err), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU, one edge of latency
  function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, b);
    case (op)
      3'd0:    return a;
      3'd1:    return ~a;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return a | b;
      3'd5:    return a & b;
      3'd6:    return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) r0 <= alu_f(ALUop, r2, r3);

  function automatic logic [11:0] enc(input logic [2:0] op, rd, a, b);
    return {op, rd, a, b};
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rd_rf(input logic [2:0] a, output logic [W-1:0] d);
    dbg_raddr = a;
    #1;
    d = dbg_rdata;
  endtask

  task automatic ld(input logic [2:0] a, input logic [W-1:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  // Issue one legal instruction from IDLE and check its cycle-by-cycle timing
  task automatic issue(input vec_t v, input string nm);
    wb_t e;
    chk({nm, "_ready_pre"}, W'(instr_ready), W'(1));
    instr_valid = 1'b1; instr = v.ins;
    e.addr = v.e_addr; e.data = v.e_data;
    sb_q.push_back(e);
    @(negedge clk);
    instr_valid = 1'b0;
    chk({nm, "_aluop"}, W'(ALUop), W'(v.e_op));
    chk({nm, "_r2"}, r2, v.e_r2);
    chk({nm, "_r3"}, r3, v.e_r3);
    chk({nm, "_ready_wait"}, W'(instr_ready), W'(0));
    @(negedge clk);
    chk({nm, "_wb_on"}, W'(wb_valid), W'(1));
    @(negedge clk);
    chk({nm, "_wb_off"}, W'(wb_valid), W'(0));
    chk({nm, "_ready_post"}, W'(instr_ready), W'(1));
  endtask

  // Writeback scoreboard
  always @(negedge clk) begin
    if (rst_n && (wb_valid === 1'b1)) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", W'(wb_valid), W'(0));
      end else begin
        wb_t e;
        e = sb_q.pop_front();
        chk("wb_addr", W'(wb_addr), W'(e.addr));
        chk("wb_data", wb_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[8];
    logic [11:0]  b2b_i[3];
    wb_t          b2b_e[3];
    logic [W-1:0] d;
    logic         exp_rdy;
    int           k;

    // {instr, ALUop, r2, r3, wb_addr, wb_data, rf[rd] afterwards}
    vecs[0] = '{enc(3'd2, 3'd3, 3'd1, 3'd2), 3'd2, 32'h7fffffff, 32'h7fffffff, 3'd3, 32'hfffffffe, 32'hfffffffe};
    vecs[1] = '{enc(3'd6, 3'd6, 3'd4, 3'd5), 3'd6, 32'hfffffffe, 32'h00000003, 3'd6, 32'h00000001, 32'h00000001};
    vecs[2] = '{enc(3'd6, 3'd6, 3'd5, 3'd4), 3'd6, 32'h00000003, 32'hfffffffe, 3'd6, 32'h00000000, 32'h00000000};
    vecs[3] = '{enc(3'd3, 3'd0, 3'd5, 3'd4), 3'd3, 32'h00000003, 32'hfffffffe, 3'd0, 32'h00000005, 32'h00000000};
    vecs[4] = '{enc(3'd4, 3'd7, 3'd1, 3'd4), 3'd4, 32'h7fffffff, 32'hfffffffe, 3'd7, 32'hffffffff, 32'hffffffff};
    vecs[5] = '{enc(3'd5, 3'd7, 3'd1, 3'd4), 3'd5, 32'h7fffffff, 32'hfffffffe, 3'd7, 32'h7ffffffe, 32'h7ffffffe};
    vecs[6] = '{enc(3'd1, 3'd7, 3'd5, 3'd0), 3'd1, 32'h00000003, 32'h00000000, 3'd7, 32'hfffffffc, 32'hfffffffc};
    vecs[7] = '{enc(3'd0, 3'd7, 3'd3, 3'd6), 3'd0, 32'hfffffffe, 32'h00000000, 3'd7, 32'hfffffffe, 32'hfffffffe};

    b2b_i[0] = enc(3'd2, 3'd7, 3'd1, 3'd0); b2b_e[0] = '{3'd7, 32'h7fffffff};
    b2b_i[1] = enc(3'd4, 3'd6, 3'd4, 3'd5); b2b_e[1] = '{3'd6, 32'hffffffff};
    b2b_i[2] = enc(3'd3, 3'd7, 3'd5, 3'd5); b2b_e[2] = '{3'd7, 32'h00000000};

    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; dbg_raddr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_ready", W'(instr_ready), W'(1));
    chk("rst_aluop", W'(ALUop), W'(0));
    chk("rst_r2", r2, '0);
    chk("rst_r3", r3, '0);
    chk("rst_wb_valid", W'(wb_valid), W'(0));
    chk("rst_wb_addr", W'(wb_addr), W'(0));
    chk("rst_wb_data", wb_data, '0);
    chk("rst_err", W'(err), W'(0));
    for (int i = 0; i < 8; i++) begin
      rd_rf(3'(i), d);
      chk($sformatf("rst_rf%0d", i), d, '0);
    end
    @(negedge clk);

    ld(3'd1, 32'h7fffffff);
    ld(3'd2, 32'h7fffffff);
    ld(3'd4, 32'hfffffffe);
    ld(3'd5, 32'h00000003);

    // Table of single instructions
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i], $sformatf("vec%0d", i));
      rd_rf(vecs[i].ins[8:6], d);
      chk($sformatf("vec%0d_rf", i), d, vecs[i].e_rf);
    end

    // Back-to-back: valid held high, accepts every 3rd edge
    k = 0;
    for (int c = 0; c < 9; c++) begin
      exp_rdy = ((c % 3) == 0);
      chk($sformatf("b2b_ready_c%0d", c), W'(instr_ready), W'(exp_rdy));
      if (k < 3) begin
        instr_valid = 1'b1; instr = b2b_i[k];
        if (exp_rdy) begin
          sb_q.push_back(b2b_e[k]);
          k++;
        end
      end else begin
        instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    rd_rf(3'd6, d);
    chk("b2b_rf6", d, 32'hffffffff);
    rd_rf(3'd7, d);
    chk("b2b_rf7", d, 32'h00000000);

    // Load to rd during the WB cycle: writeback wins
    instr_valid = 1'b1; instr = enc(3'd3, 3'd3, 3'd5, 3'd4);
    sb_q.push_back('{3'd3, 32'h00000005});
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("ldwb_wb_on", W'(wb_valid), W'(1));
    ld_valid = 1'b1; ld_addr = 3'd3; ld_data = 32'h12345678;
    @(negedge clk);
    ld_valid = 1'b0;
    rd_rf(3'd3, d);
    chk("ldwb_rf3", d, 32'h00000005);

    // Load to an issued source during WAIT: operands keep the old value
    instr_valid = 1'b1; instr = enc(3'd2, 3'd7, 3'd5, 3'd5);
    sb_q.push_back('{3'd7, 32'h00000006});
    @(negedge clk);
    instr_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 3'd5; ld_data = 32'h00000064;
    @(negedge clk);
    ld_valid = 1'b0;
    chk("ldwait_r2", r2, 32'h00000003);
    chk("ldwait_wb_on", W'(wb_valid), W'(1));
    @(negedge clk);
    rd_rf(3'd5, d);
    chk("ldwait_rf5", d, 32'h00000064);
    rd_rf(3'd7, d);
    chk("ldwait_rf7", d, 32'h00000006);

    // Illegal op: err pulse, nothing issued
    instr_valid = 1'b1; instr = enc(3'd7, 3'd1, 3'd1, 3'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("ill_err", W'(err), W'(1));
    chk("ill_aluop", W'(ALUop), W'(2));
    chk("ill_r2", r2, 32'h00000003);
    chk("ill_ready", W'(instr_ready), W'(1));
    @(negedge clk);
    chk("ill_err_off", W'(err), W'(0));
    chk("ill_wb", W'(wb_valid), W'(0));
    rd_rf(3'd1, d);
    chk("ill_rf1", d, 32'h7fffffff);

    // Reset during WAIT aborts the writeback
    instr_valid = 1'b1; instr = enc(3'd2, 3'd2, 3'd1, 3'd2);
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstw_wb", W'(wb_valid), W'(0));
    chk("rstw_ready", W'(instr_ready), W'(1));
    chk("rstw_aluop", W'(ALUop), W'(0));
    @(negedge clk);
    chk("rstw_wb2", W'(wb_valid), W'(0));
    for (int i = 1; i < 8; i++) begin
      rd_rf(3'(i), d);
      chk($sformatf("rstw_rf%0d", i), d, '0);
    end

    chk("sb_drain", W'(sb_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
